// File: rtl/reg_file_param_if.sv
// reg_file_param_if
// Bundles the data, control and read-port signals of the parametrised
// register file. The master modport drives the controls and observes the
// read ports and flags. The slave modport is the register-file side.
//   load    : data for the load function
//   funsel  : 3-bit function select, applied to every enabled register
//   rsel    : GP register enables, bit i -> GP register i
//   tsel    : TMP register enables, bit j -> register NUM_GP+j
//   o1sel   : read port 1 index
//   o2sel   : read port 2 index
//   o1, o2  : read port data; 0 for an out-of-range index
//   zero    : per-register zero flags
//   wrap    : registered carry/borrow/shift-out flag
interface reg_file_param_if #(
   parameter int WIDTH   = 8,
   parameter int NUM_GP  = 4,
   parameter int NUM_TMP = 4
);
   localparam int NUM_REG = NUM_GP + NUM_TMP;
   localparam int SW      = (NUM_REG > 1) ? $clog2(NUM_REG) : 1;

   logic [WIDTH-1:0]   load;
   logic [2:0]         funsel;
   logic [NUM_GP-1:0]  rsel;
   logic [NUM_TMP-1:0] tsel;
   logic [SW-1:0]      o1sel;
   logic [SW-1:0]      o2sel;
   logic [WIDTH-1:0]   o1;
   logic [WIDTH-1:0]   o2;
   logic [NUM_REG-1:0] zero;
   logic               wrap;

   modport master (
      output load, funsel, rsel, tsel, o1sel, o2sel,
      input  o1, o2, zero, wrap
   );

   modport slave (
      input  load, funsel, rsel, tsel, o1sel, o2sel,
      output o1, o2, zero, wrap
   );
endinterface

// File: rtl/reg_file_param.sv
// reg_file_param
// Parametrised GP/TMP register file that feeds the ALU inputs. Every enabled
// register applies the same function each clock: clear, load, decrement,
// increment, shift left, shift right, rotate left or hold. There are two
// combinational read ports, per-register zero flags and a one-cycle wrap
// flag.
//   clk : rising-edge clock
//   rst : synchronous active-high reset. It loads RESET_VAL into every
//         register and clears wrap.
//   bus : reg_file_param_if slave modport (controls, read ports, flags)
module reg_file_param #(
   parameter int               WIDTH     = 8,
   parameter int               NUM_GP    = 4,
   parameter int               NUM_TMP   = 4,
   parameter logic [WIDTH-1:0] RESET_VAL = {WIDTH{1'b0}}
) (
   input logic              clk,
   input logic              rst,
   reg_file_param_if.slave  bus
);
   localparam int NUM_REG  = NUM_GP + NUM_TMP;
   localparam int SW       = (NUM_REG > 1) ? $clog2(NUM_REG) : 1;
   localparam int RD_DEPTH = 2 ** SW;
   localparam logic [WIDTH-1:0] ONE_C = {{(WIDTH-1){1'b0}}, 1'b1};
   localparam logic [WIDTH-1:0] ONES_C = {WIDTH{1'b1}};

   // Next value of one register under function fs.
   function automatic logic [WIDTH-1:0] next_val(input logic [2:0]       fs,
                                                 input logic [WIDTH-1:0] cur,
                                                 input logic [WIDTH-1:0] ld);
      logic [WIDTH-1:0] res;
      case (fs)
         3'b000:  res = RESET_VAL;
         3'b001:  res = ld;
         3'b010:  res = cur - ONE_C;
         3'b011:  res = cur + ONE_C;
         3'b100:  res = cur << 1'b1;
         3'b101:  res = cur >> 1'b1;
         3'b110:  res = (cur << 1'b1) | (cur >> (WIDTH - 1));
         3'b111:  res = cur;
         default: res = cur;
      endcase
      return res;
   endfunction

   // Carry/borrow or shifted-out bit of one register under function fs.
   // Rotate, load, clear and hold never wrap.
   function automatic logic wrap_of(input logic [2:0]       fs,
                                    input logic [WIDTH-1:0] cur);
      logic res;
      case (fs)
         3'b010:  res = (cur == {WIDTH{1'b0}});
         3'b011:  res = (cur == ONES_C);
         3'b100:  res = cur[WIDTH-1];
         3'b101:  res = cur[0];
         default: res = 1'b0;
      endcase
      return res;
   endfunction

   logic [WIDTH-1:0]   regs_r [NUM_REG];
   logic [WIDTH-1:0]   next_s [NUM_REG];
   logic [WIDTH-1:0]   rd_s   [RD_DEPTH];
   logic [NUM_REG-1:0] en_s;
   logic [NUM_REG-1:0] zero_s;
   logic               wrap_next_s;
   logic               wrap_r;

   // GP enables occupy the low indices and TMP enables follow them.
   assign en_s = {bus.tsel, bus.rsel};

   // Next register state and wrap flag for the current controls.
   always_comb begin
      wrap_next_s = 1'b0;
      for (int k = 0; k < NUM_REG; k++) begin
         next_s[k]   = en_s[k] ? next_val(bus.funsel, regs_r[k], bus.load) : regs_r[k];
         wrap_next_s = wrap_next_s | (en_s[k] & wrap_of(bus.funsel, regs_r[k]));
      end
   end

   // Register and wrap-flag state. Reset takes priority over every function.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int k = 0; k < NUM_REG; k++) begin
            regs_r[k] <= RESET_VAL;
         end
         wrap_r <= 1'b0;
      end else begin
         for (int k = 0; k < NUM_REG; k++) begin
            regs_r[k] <= next_s[k];
         end
         wrap_r <= wrap_next_s;
      end
   end

   // Pad the read table to a power of two so that out-of-range indices read 0.
   for (genvar i = 0; i < RD_DEPTH; i++) begin : g_rd
      if (i < NUM_REG) begin : g_reg
         assign rd_s[i] = regs_r[i];
      end else begin : g_pad
         assign rd_s[i] = {WIDTH{1'b0}};
      end
   end

   // Per-register zero flags, from the current register state.
   always_comb begin
      zero_s = {NUM_REG{1'b0}};
      for (int k = 0; k < NUM_REG; k++) begin
         zero_s[k] = (regs_r[k] == {WIDTH{1'b0}});
      end
   end

   // Reads show the pre-edge value. Writes do not bypass to the read ports.
   assign bus.o1   = rd_s[bus.o1sel];
   assign bus.o2   = rd_s[bus.o2sel];
   assign bus.zero = zero_s;
   assign bus.wrap = wrap_r;
endmodule

// File: tb/tb_reg_file_param.sv
// tb_reg_file_param
// Directed test of reg_file_param with a scoreboard. The stimulus pushes
// hand-computed expected read/flag values into a queue. The monitor pops and
// compares them on the falling clock edge.
// dut0: WIDTH=8, NUM_GP=4, NUM_TMP=4.
// dut1: WIDTH=8, NUM_GP=3, NUM_TMP=3. dut1 covers out-of-range reads.
module tb_reg_file_param;
   logic clk;
   logic rst;

   reg_file_param_if #(.WIDTH(8), .NUM_GP(4), .NUM_TMP(4)) bus0 ();
   reg_file_param_if #(.WIDTH(8), .NUM_GP(3), .NUM_TMP(3)) bus1 ();

   reg_file_param #(.WIDTH(8), .NUM_GP(4), .NUM_TMP(4), .RESET_VAL(8'h00)) dut0 (
      .clk (clk),
      .rst (rst),
      .bus (bus0)
   );

   reg_file_param #(.WIDTH(8), .NUM_GP(3), .NUM_TMP(3), .RESET_VAL(8'h00)) dut1 (
      .clk (clk),
      .rst (rst),
      .bus (bus1)
   );

   typedef struct {
      string      name;
      int         dut;
      logic [7:0] o1;
      logic [7:0] o2;
      logic [7:0] zero;
      logic       wrap;
   } exp_t;

   exp_t exp_q[$];
   int   checks_total;
   int   checks_passed;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Scoreboard monitor: compare every queued expectation on the falling edge.
   always @(negedge clk) begin
      exp_t       e;
      logic [7:0] a_o1, a_o2, a_zero;
      logic       a_wrap;
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         if (e.dut == 0) begin
            a_o1 = bus0.o1; a_o2 = bus0.o2; a_zero = bus0.zero; a_wrap = bus0.wrap;
         end else begin
            a_o1 = bus1.o1; a_o2 = bus1.o2; a_zero = {2'b00, bus1.zero}; a_wrap = bus1.wrap;
         end
         checks_total++;
         if (a_o1 !== e.o1 || a_o2 !== e.o2 || a_zero !== e.zero || a_wrap !== e.wrap)
            $display("FAIL %s: got o1=%h o2=%h zero=%b wrap=%b, expected o1=%h o2=%h zero=%b wrap=%b",
                     e.name, a_o1, a_o2, a_zero, a_wrap, e.o1, e.o2, e.zero, e.wrap);
         else
            checks_passed++;
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive0(input logic [2:0] fs, input logic [7:0] ld,
                         input logic [3:0] r, input logic [3:0] t);
      bus0.funsel = fs; bus0.load = ld; bus0.rsel = r; bus0.tsel = t;
   endtask

   // Select read indices, queue the expectation, then let the monitor sample.
   task automatic expect_st(input string nm, input int d,
                            input logic [2:0] s1, input logic [2:0] s2,
                            input logic [7:0] e1, input logic [7:0] e2,
                            input logic [7:0] ez, input logic ew);
      exp_t e;
      if (d == 0) begin
         bus0.o1sel = s1; bus0.o2sel = s2;
      end else begin
         bus1.o1sel = s1; bus1.o2sel = s2;
      end
      e.name = nm; e.dut = d; e.o1 = e1; e.o2 = e2; e.zero = ez; e.wrap = ew;
      exp_q.push_back(e);
      @(negedge clk);
      #1;
   endtask

   initial begin
      #100000;
      $display("FAIL timeout: simulation did not finish, got no end, required end");
      $fatal(1, "timeout");
   end

   initial begin
      checks_total  = 0;
      checks_passed = 0;
      rst = 1'b1;
      drive0(3'b001, 8'hAA, 4'hF, 4'hF);
      bus0.o1sel = 3'd0; bus0.o2sel = 3'd7;
      bus1.funsel = 3'b001; bus1.load = 8'h5A; bus1.rsel = 3'b111; bus1.tsel = 3'b111;
      bus1.o1sel = 3'd0; bus1.o2sel = 3'd0;

      // Reset beats a concurrent load. Then present a load and check pre-edge.
      tick();
      rst = 1'b0;
      bus1.funsel = 3'b111;
      drive0(3'b001, 8'h95, 4'b0100, 4'b0001);
      expect_st("reset_prewrite", 0, 3'd2, 3'd4, 8'h00, 8'h00, 8'hFF, 1'b0);
      tick();
      expect_st("load_gp2_tmp0", 0, 3'd2, 3'd4, 8'h95, 8'h95, 8'hEB, 1'b0);

      // Increment GP2 through all-ones.
      drive0(3'b001, 8'hFF, 4'b0100, 4'b0000);
      tick();
      expect_st("load_ff", 0, 3'd2, 3'd2, 8'hFF, 8'hFF, 8'hEB, 1'b0);
      drive0(3'b011, 8'h00, 4'b0100, 4'b0000);
      tick();
      expect_st("inc_wrap", 0, 3'd2, 3'd4, 8'h00, 8'h95, 8'hEF, 1'b1);
      tick();
      expect_st("inc_nowrap", 0, 3'd2, 3'd4, 8'h01, 8'h95, 8'hEB, 1'b0);

      // Clear TMP0, decrement it through zero, then hold.
      drive0(3'b000, 8'h00, 4'b0000, 4'b0001);
      tick();
      expect_st("clear_tmp0", 0, 3'd4, 3'd2, 8'h00, 8'h01, 8'hFB, 1'b0);
      drive0(3'b010, 8'h00, 4'b0000, 4'b0001);
      tick();
      expect_st("dec_wrap", 0, 3'd4, 3'd2, 8'hFF, 8'h01, 8'hEB, 1'b1);
      drive0(3'b111, 8'h00, 4'b0000, 4'b0001);
      tick();
      expect_st("hold1", 0, 3'd4, 3'd2, 8'hFF, 8'h01, 8'hEB, 1'b0);
      tick();
      expect_st("hold2", 0, 3'd4, 3'd2, 8'hFF, 8'h01, 8'hEB, 1'b0);

      // Shifts and rotate on GP1.
      drive0(3'b001, 8'h95, 4'b0010, 4'b0000);
      tick();
      expect_st("load_gp1", 0, 3'd1, 3'd4, 8'h95, 8'hFF, 8'hE9, 1'b0);
      drive0(3'b100, 8'h00, 4'b0010, 4'b0000);
      tick();
      expect_st("shl", 0, 3'd1, 3'd4, 8'h2A, 8'hFF, 8'hE9, 1'b1);
      drive0(3'b001, 8'h95, 4'b0010, 4'b0000);
      tick();
      expect_st("reload1", 0, 3'd1, 3'd4, 8'h95, 8'hFF, 8'hE9, 1'b0);
      drive0(3'b101, 8'h00, 4'b0010, 4'b0000);
      tick();
      expect_st("shr", 0, 3'd1, 3'd4, 8'h4A, 8'hFF, 8'hE9, 1'b1);
      drive0(3'b001, 8'h95, 4'b0010, 4'b0000);
      tick();
      expect_st("reload2", 0, 3'd1, 3'd4, 8'h95, 8'hFF, 8'hE9, 1'b0);
      drive0(3'b110, 8'h00, 4'b0010, 4'b0000);
      tick();
      expect_st("rotl", 0, 3'd1, 3'd4, 8'h2B, 8'hFF, 8'hE9, 1'b0);

      // No enables: nothing changes, wrap stays 0 even for a decrement.
      drive0(3'b010, 8'h00, 4'b0000, 4'b0000);
      tick();
      expect_st("no_enable", 0, 3'd1, 3'd4, 8'h2B, 8'hFF, 8'hE9, 1'b0);

      // Reset in the middle of an increment run, then resume.
      drive0(3'b011, 8'h00, 4'b1111, 4'b1111);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      expect_st("reset_mid", 0, 3'd1, 3'd7, 8'h00, 8'h00, 8'hFF, 1'b0);
      tick();
      expect_st("resume_inc", 0, 3'd1, 3'd7, 8'h01, 8'h01, 8'h00, 1'b0);

      // dut1 (3+3 registers): out-of-range reads and TMP2 at index 5.
      bus1.funsel = 3'b001; bus1.load = 8'h3C; bus1.rsel = 3'b000; bus1.tsel = 3'b100;
      tick();
      bus1.funsel = 3'b111;
      expect_st("oor_reads", 1, 3'd6, 3'd7, 8'h00, 8'h00, 8'h1F, 1'b0);
      expect_st("tmp2_read", 1, 3'd5, 3'd6, 8'h3C, 8'h00, 8'h1F, 1'b0);

      @(negedge clk);
      #1;
      if (exp_q.size() != 0) begin
         checks_total++;
         $display("FAIL scoreboard_drain: got %0d pending, required 0", exp_q.size());
      end
      $display("%0d/%0d checks passed", checks_passed, checks_total);
      $finish;
   end
endmodule
